fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 5-stage MIPS-lite pipeline (no-forwarding build).
- Owns the program counter and drives the address and squash inputs of the combinational instruction memory.
- Registers fetched words into the IF/ID pipeline register.
- Applies hazard-unit stalls, branch redirects with bubble insertion, HALT detection and fetch-fault detection.

Parameters:
- ADDRESSWIDTH, 32: PC and memory byte-address width.
- MEM_BYTES, 4096: instruction memory size in bytes. Valid PC range is 0..MEM_BYTES-4.
- RESET_PC, 0: PC value after reset.
- HALT_OPCODE, 6'h11: instr[31:26] value that identifies HALT.
- NOP_WORD, 32'h0000_0000: word injected as a bubble.

Ports:
- clk  input  1  pipeline clock. All state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hazard-unit stall. Holds PC and IF/ID.
- branch_taken_i  input  1  taken branch resolved this cycle.
- branch_target_i  input  ADDRESSWIDTH  redirect byte address.
- imem_addr_o  output  ADDRESSWIDTH  fetch address to instruction memory.
- imem_branch_taken_o  output  1  squash input to instruction memory.
- imem_rdata_i  input  32  word returned by instruction memory in the same cycle.
- ifid_instr_o  output  32  IF/ID instruction.
- ifid_pc_o  output  ADDRESSWIDTH  IF/ID instruction address.
- ifid_pcplus4_o  output  ADDRESSWIDTH  IF/ID PC+4.
- ifid_valid_o  output  1  IF/ID holds a real instruction.
- halted_o  output  1  fetch stopped on HALT.
- fault_o  output  1  fetch stopped on a bad address (sticky).
- fetch_count_o  output  32  count of valid IF/ID loads.

Behaviour:
- Reset (async assert, sync-released use):
  - pc = RESET_PC; state = RUN.
  - ifid_instr_o = NOP_WORD; ifid_pc_o = 0; ifid_pcplus4_o = 0; ifid_valid_o = 0.
  - halted_o = 0; fault_o = 0; fetch_count_o = 0.
  - Reset mid-operation discards all state with no residue.
- Combinational outputs:
  - imem_addr_o = pc.
  - imem_branch_taken_o = branch_taken_i. Memory returns DEADBEEF; that word is never latched.
- State encodings: RUN, HALTED, FAULT. halted_o = (state==HALTED); fault_o = (state==FAULT).
- Per-cycle priority in RUN: branch_taken_i > stall_i > normal fetch.
  - Branch:
    - If target[1:0]!=0 or target > MEM_BYTES-4: go to FAULT and hold pc.
    - Otherwise pc <= target.
    - In both cases IF/ID <= bubble (NOP_WORD, valid 0, pc fields 0).
    - Redirect penalty is exactly 1 bubble; the target word is latched on the next unstalled edge.
  - Stall: pc and all IF/ID outputs hold; counter holds.
  - Normal fetch:
    - IF/ID <= {imem_rdata_i, pc, pc+4, valid 1}; fetch_count_o += 1, saturating at 32'hFFFF_FFFF.
    - If imem_rdata_i[31:26]==HALT_OPCODE: latch the HALT word, hold pc, go to HALTED.
    - Else if pc+4 > MEM_BYTES-4 (top-of-memory wrap): latch the word, hold pc, go to FAULT.
    - Else pc <= pc+4.
- HALTED:
  - A taken branch from an older instruction makes the speculative HALT void: apply the branch rule above, then RUN or FAULT.
  - If stall_i: hold IF/ID.
  - Otherwise inject a bubble every cycle. pc holds.
- FAULT:
  - Terminal until reset.
  - Stall holds IF/ID; otherwise bubbles are injected.
  - branch_taken_i is ignored. pc holds.
- Simultaneous stall_i and branch_taken_i: the branch wins. The hazard unit never asserts a stall that must survive a redirect.
- Stall duration is unbounded; behaviour is identical for every stalled cycle.

Test Plan:
- Sequential fetch: reset; memory words at 0x0,0x4,0x8 = 0x20010005, 0x20020003, 0x00221820; no stall -> IF/ID shows those words over 3 edges with pc 0x0/0x4/0x8, valid 1, fetch_count_o=3.
- Stall: assert stall_i for 2 cycles while pc=0x8 -> ifid_pc_o stays 0x4, imem_addr_o stays 0x8, count unchanged; release -> word at 0x8 latched.
- Branch with simultaneous stall: branch_taken_i=1, stall_i=1, target=0x40, pc=0x10 -> next edge valid 0, instr 0x0, pc=0x40; following edge IF/ID holds pc 0x40 and the word at 0x40.
- HALT: word 0x44000000 at 0x0C -> latched with valid 1, halted_o=1, pc stays 0x0C, then bubbles each cycle. A later branch to 0x20 -> halted_o=0, fetch resumes at 0x20.
- Faults:
  - Target 0x42 -> fault_o=1, bubbles only.
  - With MEM_BYTES=16, fetch at 0xC -> word latched, then fault_o=1.
  - Async rst_n pulse in FAULT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: hazard/branch control, instruction-memory
// handshake and IF/ID pipeline register outputs.
// Modports:
//   master - environment side: drives stall, branch and memory read data.
//   slave  - fetch_sequencer side: drives memory address/squash, IF/ID and status.
// Signals:
//   stall_i, branch_taken_i, branch_target_i : pipeline control into fetch
//   imem_addr_o, imem_branch_taken_o         : request to instruction memory
//   imem_rdata_i                             : same-cycle word from memory
//   ifid_instr_o, ifid_pc_o, ifid_pcplus4_o,
//   ifid_valid_o                             : IF/ID pipeline register
//   halted_o, fault_o, fetch_count_o         : fetch status
interface fetch_sequencer_if #(
    parameter int unsigned ADDRESSWIDTH = 32
) ();
    logic                    stall_i;
    logic                    branch_taken_i;
    logic [ADDRESSWIDTH-1:0] branch_target_i;
    logic [ADDRESSWIDTH-1:0] imem_addr_o;
    logic                    imem_branch_taken_o;
    logic [31:0]             imem_rdata_i;
    logic [31:0]             ifid_instr_o;
    logic [ADDRESSWIDTH-1:0] ifid_pc_o;
    logic [ADDRESSWIDTH-1:0] ifid_pcplus4_o;
    logic                    ifid_valid_o;
    logic                    halted_o;
    logic                    fault_o;
    logic [31:0]             fetch_count_o;

    modport master (
        output stall_i, branch_taken_i, branch_target_i, imem_rdata_i,
        input  imem_addr_o, imem_branch_taken_o, ifid_instr_o, ifid_pc_o,
               ifid_pcplus4_o, ifid_valid_o, halted_o, fault_o, fetch_count_o
    );

    modport slave (
        input  stall_i, branch_taken_i, branch_target_i, imem_rdata_i,
        output imem_addr_o, imem_branch_taken_o, ifid_instr_o, ifid_pc_o,
               ifid_pcplus4_o, ifid_valid_o, halted_o, fault_o, fetch_count_o
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the 5-stage MIPS-lite pipeline.
// Owns the PC, drives the combinational instruction memory, registers the
// fetched word into IF/ID, and handles stalls, branch redirects (one bubble),
// HALT detection and fetch faults (bad branch target or top-of-memory wrap).
// Ports:
//   clk   - pipeline clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - fetch_sequencer_if.slave (control in, memory handshake, IF/ID, status)
module fetch_sequencer #(
    parameter int unsigned           ADDRESSWIDTH = 32,
    parameter int unsigned           MEM_BYTES    = 4096,
    parameter logic [ADDRESSWIDTH-1:0] RESET_PC   = '0,
    parameter logic [5:0]            HALT_OPCODE  = 6'h11,
    parameter logic [31:0]           NOP_WORD     = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst_n,
    fetch_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StRun, StHalted, StFault} state_e;

    // Highest legal fetch address, one bit wider so pc+4 cannot wrap in the compare.
    localparam logic [ADDRESSWIDTH:0] LastPc = (ADDRESSWIDTH+1)'(MEM_BYTES - 4);

    state_e                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] pc_q, pc_d;
    logic [31:0]             instr_q, instr_d;
    logic [ADDRESSWIDTH-1:0] ipc_q, ipc_d;
    logic [ADDRESSWIDTH-1:0] ipc4_q, ipc4_d;
    logic                    valid_q, valid_d;
    logic [31:0]             count_q, count_d;

    logic [ADDRESSWIDTH:0]   pc_plus4_ext;
    logic                    target_bad;
    logic                    is_halt;

    assign pc_plus4_ext = {1'b0, pc_q} + (ADDRESSWIDTH+1)'(4);
    assign target_bad   = (bus.branch_target_i[1:0] != 2'b00) ||
                          ({1'b0, bus.branch_target_i} > LastPc);
    assign is_halt      = (bus.imem_rdata_i[31:26] == HALT_OPCODE);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            ipc_q   <= '0;
            ipc4_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        valid_d = valid_q;
        count_d = count_q;

        unique case (state_q)
            StRun, StHalted: begin
                if (bus.branch_taken_i) begin
                    // A redirect voids any speculative HALT; the squashed word is never latched.
                    instr_d = NOP_WORD;
                    ipc_d   = '0;
                    ipc4_d  = '0;
                    valid_d = 1'b0;
                    if (target_bad) begin
                        state_d = StFault;
                    end else begin
                        state_d = StRun;
                        pc_d    = bus.branch_target_i;
                    end
                end else if (bus.stall_i) begin
                    // Hold everything.
                end else if (state_q == StRun) begin
                    instr_d = bus.imem_rdata_i;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_plus4_ext[ADDRESSWIDTH-1:0];
                    valid_d = 1'b1;
                    count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
                    if (is_halt) begin
                        state_d = StHalted;
                    end else if (pc_plus4_ext > LastPc) begin
                        state_d = StFault;
                    end else begin
                        pc_d = pc_plus4_ext[ADDRESSWIDTH-1:0];
                    end
                end else begin
                    instr_d = NOP_WORD;
                    ipc_d   = '0;
                    ipc4_d  = '0;
                    valid_d = 1'b0;
                end
            end
            StFault: begin
                // Terminal: branches ignored, bubbles unless stalled.
                if (!bus.stall_i) begin
                    instr_d = NOP_WORD;
                    ipc_d   = '0;
                    ipc4_d  = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StFault;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        bus.imem_addr_o         = pc_q;
        bus.imem_branch_taken_o = bus.branch_taken_i;
        bus.ifid_instr_o        = instr_q;
        bus.ifid_pc_o           = ipc_q;
        bus.ifid_pcplus4_o      = ipc4_q;
        bus.ifid_valid_o        = valid_q;
        bus.halted_o            = (state_q == StHalted);
        bus.fault_o             = (state_q == StFault);
        bus.fetch_count_o       = count_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    localparam int unsigned AW = 32;
    localparam int unsigned MB = 256;
    localparam int unsigned NW = MB / 4;
    localparam int MRun = 0, MHalted = 1, MFault = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDRESSWIDTH(AW)) bus ();
    fetch_sequencer_if #(.ADDRESSWIDTH(AW)) bus2 ();

    fetch_sequencer #(.ADDRESSWIDTH(AW), .MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    fetch_sequencer #(.ADDRESSWIDTH(AW), .MEM_BYTES(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    logic [31:0] mem [NW];

    // Combinational memories; a squashed read returns DEADBEEF.
    assign bus.imem_rdata_i = bus.imem_branch_taken_o ? 32'hDEADBEEF :
                              (bus.imem_addr_o < 32'(MB)) ? mem[bus.imem_addr_o[7:2]] :
                              32'hDEADBEEF;
    assign bus2.imem_rdata_i    = 32'h1111_0000 + bus2.imem_addr_o;
    assign bus2.stall_i         = 1'b0;
    assign bus2.branch_taken_i  = 1'b0;
    assign bus2.branch_target_i = '0;

    // Behavioural model.
    int          m_state;
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic        m_valid;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = MRun; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic br, input logic [31:0] tgt);
        logic [31:0] w;
        logic        bad;
        bad = (tgt % 4 != 0) || (tgt > MB - 4);
        if (m_state != MFault && br) begin
            model_bubble();
            if (bad) m_state = MFault;
            else begin m_state = MRun; m_pc = tgt; end
        end else if (st) begin
            // everything holds
        end else if (m_state == MRun) begin
            w = mem[m_pc / 4];
            m_instr = w; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_valid = 1'b1;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (w[31:26] == 6'h11) m_state = MHalted;
            else if (m_pc + 4 > MB - 4) m_state = MFault;
            else m_pc = m_pc + 4;
        end else begin
            model_bubble();
        end
    endtask

    task automatic check_all();
        chk("imem_addr", bus.imem_addr_o, m_pc);
        chk("ifid_instr", bus.ifid_instr_o, m_instr);
        chk("ifid_pc", bus.ifid_pc_o, m_ipc);
        chk("ifid_pcplus4", bus.ifid_pcplus4_o, m_ipc4);
        chk("ifid_valid", {31'b0, bus.ifid_valid_o}, {31'b0, m_valid});
        chk("halted", {31'b0, bus.halted_o}, (m_state == MHalted) ? 32'd1 : 32'd0);
        chk("fault", {31'b0, bus.fault_o}, (m_state == MFault) ? 32'd1 : 32'd0);
        chk("fetch_count", bus.fetch_count_o, m_cnt);
    endtask

    // One clock: drive inputs after the previous edge, check comb outputs,
    // advance the model, then check registered outputs just after the edge.
    task automatic do_cycle(input logic st, input logic br, input logic [31:0] tgt);
        bus.stall_i = st; bus.branch_taken_i = br; bus.branch_target_i = tgt;
        #1;
        chk("imem_squash", {31'b0, bus.imem_branch_taken_o}, {31'b0, br});
        chk("imem_addr_pre", bus.imem_addr_o, m_pc);
        model_step(st, br, tgt);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        bus.stall_i = 1'b0; bus.branch_taken_i = 1'b0; bus.branch_target_i = '0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic randomize_mem();
        logic [31:0] w;
        for (int i = 0; i < int'(NW); i++) begin
            w = $urandom;
            if ($urandom_range(0, 15) == 0) w[31:26] = 6'h11;
            else if (w[31:26] == 6'h11) w[31:26] = 6'h00;
            mem[i] = w;
        end
    endtask

    initial begin
        logic [31:0] tgt;
        bus.stall_i = 1'b0; bus.branch_taken_i = 1'b0; bus.branch_target_i = '0;
        for (int i = 0; i < int'(NW); i++) mem[i] = 32'h0;
        mem[0] = 32'h2001_0005; mem[1] = 32'h2002_0003; mem[2] = 32'h0022_1820;
        mem[3] = 32'h4400_0000; mem[8] = 32'h2003_0007; mem[16] = 32'hAC01_0040;
        model_reset();
        @(posedge clk);
        apply_reset();
        chk("reset_count_lit", bus.fetch_count_o, 32'h0);

        // Sequential fetch and stall.
        do_cycle(0, 0, 0);
        chk("seq0_instr_lit", bus.ifid_instr_o, 32'h2001_0005);
        chk("seq0_pc4_lit", bus.ifid_pcplus4_o, 32'h4);
        do_cycle(0, 0, 0);
        do_cycle(1, 0, 0);
        do_cycle(1, 0, 0);
        chk("stall_pc_lit", bus.ifid_pc_o, 32'h4);
        chk("stall_addr_lit", bus.imem_addr_o, 32'h8);
        chk("stall_count_lit", bus.fetch_count_o, 32'd2);
        do_cycle(0, 0, 0);
        chk("seq2_instr_lit", bus.ifid_instr_o, 32'h0022_1820);
        chk("seq2_count_lit", bus.fetch_count_o, 32'd3);

        // HALT at 0xC, bubbles, then revived by a branch to 0x20.
        do_cycle(0, 0, 0);
        chk("halt_instr_lit", bus.ifid_instr_o, 32'h4400_0000);
        chk("halt_flag_lit", {31'b0, bus.halted_o}, 32'd1);
        do_cycle(0, 0, 0);
        chk("halt_bubble_lit", {31'b0, bus.ifid_valid_o}, 32'd0);
        chk("halt_addr_lit", bus.imem_addr_o, 32'hC);
        do_cycle(0, 1, 32'h20);
        chk("unhalt_lit", {31'b0, bus.halted_o}, 32'd0);
        do_cycle(0, 0, 0);
        chk("resume_instr_lit", bus.ifid_instr_o, 32'h2003_0007);
        chk("resume_pc_lit", bus.ifid_pc_o, 32'h20);

        // Branch with simultaneous stall.
        do_cycle(1, 1, 32'h40);
        chk("brst_valid_lit", {31'b0, bus.ifid_valid_o}, 32'd0);
        chk("brst_addr_lit", bus.imem_addr_o, 32'h40);
        do_cycle(0, 0, 0);
        chk("brst_pc_lit", bus.ifid_pc_o, 32'h40);
        chk("brst_instr_lit", bus.ifid_instr_o, 32'hAC01_0040);

        // Misaligned target faults; fault ignores branches.
        do_cycle(0, 1, 32'h42);
        chk("fault_lit", {31'b0, bus.fault_o}, 32'd1);
        do_cycle(0, 0, 0);
        do_cycle(0, 1, 32'h10);
        chk("fault_hold_addr_lit", bus.imem_addr_o, 32'h44);

        // Async reset in FAULT.
        apply_reset();
        chk("rst_fault_lit", {31'b0, bus.fault_o}, 32'd0);
        chk("rst_addr_lit", bus.imem_addr_o, 32'h0);

        // Small-memory instance: top-of-memory wrap at 0xC.
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 0);
        chk("wrap_pc_lit", bus2.ifid_pc_o, 32'hC);
        chk("wrap_instr_lit", bus2.ifid_instr_o, 32'h1111_000C);
        chk("wrap_valid_lit", {31'b0, bus2.ifid_valid_o}, 32'd1);
        chk("wrap_fault_lit", {31'b0, bus2.fault_o}, 32'd1);
        chk("wrap_count_lit", bus2.fetch_count_o, 32'd4);
        chk("wrap_addr_lit", bus2.imem_addr_o, 32'hC);
        do_cycle(1, 0, 0);
        chk("wrap_bubble_lit", {31'b0, bus2.ifid_valid_o}, 32'd0);

        // Randomized run against the model.
        randomize_mem();
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c % 120 == 119) begin
                randomize_mem();
                apply_reset();
            end
            case ($urandom_range(0, 9))
                0: tgt = ($urandom_range(0, NW - 1) * 4) | $urandom_range(1, 3);
                1: tgt = 32'(MB) + $urandom_range(0, 1000);
                default: tgt = $urandom_range(0, NW - 1) * 4;
            endcase
            do_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
